// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bit engine and its SCK divider.
//   spi_state_e : transaction FSM states
//   SPI_CPOL / SPI_CPHA : SPI mode-0 clock polarity and phase
//   LEN_W       : width of the bit-length fields and counters
//   min_len()   : clamp helper used when latching the write length
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode 0: SCK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int LEN_W = 24;

  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider for the SPI bit engine.
// A single phase counter is reused for the chip-select setup window, every
// bit period of the shift phase and the chip-select hold window.
// Ports:
//   clock, rst_n  : clock and asynchronous active-low reset
//   setup         : engine is in CS_SETUP (count CLK_DIV/2 cycles)
//   shift         : engine is in SHIFT (count CLK_DIV cycles per bit)
//   hold          : engine is in CS_HOLD (count CLK_DIV/2 cycles)
//   spi_sck       : serial clock, idle level SPI_CPOL
//   clk_en        : bit-boundary strobe (last setup cycle, last cycle of a bit)
//   sample        : MISO capture strobe, the cycle ending in the SCK sample edge
//   hold_end      : last cycle of the CS hold window
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic setup,
  input  logic shift,
  input  logic hold,
  output logic spi_sck,
  output logic clk_en,
  output logic sample,
  output logic hold_end
);

  localparam int HALF      = CLK_DIV / 2;
  localparam int PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SAMPLE_PH = SPI_CPHA ? (CLK_DIV - 1) : (HALF - 1);

  logic [PW-1:0] ph_q, ph_d;
  logic          last_half, last_full;

  // Half-period windows (setup/hold) wrap at HALF, bit periods at CLK_DIV;
  // the counter parks at zero outside these states so SHIFT always starts
  // on phase 0.
  always_comb begin
    last_half = (ph_q == PW'(HALF - 1));
    last_full = (ph_q == PW'(CLK_DIV - 1));
    ph_d      = '0;
    if (setup || hold) begin
      ph_d = last_half ? '0 : ph_q + PW'(1);
    end else if (shift) begin
      ph_d = last_full ? '0 : ph_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

  assign spi_sck  = (shift && (ph_q >= PW'(HALF))) ? ~SPI_CPOL : SPI_CPOL;
  assign clk_en   = (setup && last_half) || (shift && last_full);
  assign sample   = shift && (ph_q == PW'(SAMPLE_PH));
  assign hold_end = hold && last_half;

endmodule

// File: rtl/spi_bit_engine.sv
// SPI mode-0 master bit engine.
// Runs one transaction of req_len SCK bits per request: CS setup, shift,
// CS hold, then a one-cycle done. TX bytes are pulled through a
// ready/valid handshake at byte boundaries; RX bytes are presented with a
// one-cycle rd_vld pulse.
// Ports:
//   clock, rst_n            : clock and asynchronous active-low reset
//   request                 : start level, sampled only in IDLE
//   req_len, req_wr_len     : total SCK bits, bits sourced from wr_data
//   busy, done              : transaction in progress, end pulse
//   wr_data, wr_vld, wr_ready : TX byte handshake
//   clk_en                  : bit-boundary strobe
//   rd_data, rd_vld         : last complete RX byte and its update pulse
//   wr_underflow            : sticky flag, a TX byte was missing
//   spi_cs_n, spi_sck, spi_mosi, spi_miso : SPI pins
module spi_bit_engine
  import spi_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             request,
  input  logic [LEN_W-1:0] req_len,
  input  logic [LEN_W-1:0] req_wr_len,
  output logic             busy,
  output logic             done,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ready,
  output logic             clk_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_vld,
  output logic             wr_underflow,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int PW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  spi_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_len_q, wr_len_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [PW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [DSIZE-1:0] tx_sr_q, tx_sr_d;
  logic [DSIZE-1:0] rx_sr_q, rx_sr_d;
  logic [DSIZE-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             mosi_q, mosi_d;
  logic             uf_q, uf_d;
  logic [DSIZE-1:0] tx_byte;
  logic             sample, hold_end;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clock   (clock),
    .rst_n   (rst_n),
    .setup   (state_q == ST_CS_SETUP),
    .shift   (state_q == ST_SHIFT),
    .hold    (state_q == ST_CS_HOLD),
    .spi_sck (spi_sck),
    .clk_en  (clk_en),
    .sample  (sample),
    .hold_end(hold_end)
  );

  // bit_idx counts bits already launched, so it also names the next bit;
  // pos tracks that bit's position inside its byte.
  assign wr_ready = ((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT)) &&
                    (pos_q == '0) && (bit_idx_q < wr_len_q);

  // Next-state, TX launch and RX capture. Each clk_en launches the next
  // bit; the clk_en that finds every bit launched closes the last period.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_len_d  = wr_len_q;
    bit_idx_d = bit_idx_q;
    pos_d     = pos_q;
    rx_cnt_d  = rx_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    mosi_d    = mosi_q;
    uf_d      = uf_q;
    tx_byte   = wr_vld ? wr_data : '0;

    if (sample) begin
      rx_sr_d = {rx_sr_q[DSIZE-2:0], spi_miso};
      if (rx_cnt_q == PW'(DSIZE - 1)) begin
        rd_data_d = {rx_sr_q[DSIZE-2:0], spi_miso};
        rd_vld_d  = 1'b1;
        rx_cnt_d  = '0;
      end else begin
        rx_cnt_d = rx_cnt_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          len_d     = req_len;
          wr_len_d  = min_len(req_wr_len, req_len);
          uf_d      = 1'b0;
          bit_idx_d = '0;
          pos_d     = '0;
          rx_cnt_d  = '0;
          mosi_d    = 1'b0;
          state_d   = (req_len == '0) ? ST_DONE : ST_CS_SETUP;
        end
      end
      ST_CS_SETUP, ST_SHIFT: begin
        if (clk_en) begin
          if (bit_idx_q == len_q) begin
            mosi_d  = 1'b0;
            state_d = ST_CS_HOLD;
          end else begin
            // A missing byte is replaced by zeros rather than stalling SCK.
            if (wr_ready) begin
              if (!wr_vld) begin
                uf_d = 1'b1;
              end
              mosi_d  = tx_byte[DSIZE-1];
              tx_sr_d = tx_byte << 1;
            end else if (bit_idx_q < wr_len_q) begin
              mosi_d  = tx_sr_q[DSIZE-1];
              tx_sr_d = tx_sr_q << 1;
            end else begin
              mosi_d = 1'b0;
            end
            bit_idx_d = bit_idx_q + LEN_W'(1);
            pos_d     = (pos_q == PW'(DSIZE - 1)) ? '0 : pos_q + PW'(1);
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_CS_HOLD: begin
        if (hold_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      wr_len_q  <= '0;
      bit_idx_q <= '0;
      pos_q     <= '0;
      rx_cnt_q  <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      mosi_q    <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_len_q  <= wr_len_d;
      bit_idx_q <= bit_idx_d;
      pos_q     <= pos_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      mosi_q    <= mosi_d;
      uf_q      <= uf_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign spi_cs_n     = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                          (state_q == ST_CS_HOLD));
  assign spi_mosi     = mosi_q;
  assign rd_data      = rd_data_q;
  assign rd_vld       = rd_vld_q;
  assign wr_underflow = uf_q;

endmodule

// File: tb/tb_spi_bit_engine.sv
// Self-checking bench for spi_bit_engine (DSIZE=8, CLK_DIV=4).
// A table of transactions is run through one driver/monitor task; reset,
// back-to-back requests and an asynchronous mid-transaction reset are
// exercised by hand-written sequences.
module tb_spi_bit_engine;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        request = 1'b0;
  logic [23:0] req_len = '0;
  logic [23:0] req_wr_len = '0;
  logic        busy, done;
  logic [7:0]  wr_data = '0;
  logic        wr_vld = 1'b0;
  logic        wr_ready, clk_en;
  logic [7:0]  rd_data;
  logic        rd_vld, wr_underflow;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  spi_bit_engine #(
    .DSIZE  (8),
    .CLK_DIV(4)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .request     (request),
    .req_len     (req_len),
    .req_wr_len  (req_wr_len),
    .busy        (busy),
    .done        (done),
    .wr_data     (wr_data),
    .wr_vld      (wr_vld),
    .wr_ready    (wr_ready),
    .clk_en      (clk_en),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .wr_underflow(wr_underflow),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  always #5 clock = ~clock;

  // Serial fields (tx, miso, expected mosi) are left-aligned: bit k of the
  // transaction sits at [31-k].
  typedef struct {
    string       name;
    logic [23:0] len;
    logic [23:0] wrLen;
    logic [31:0] tx;
    logic        vldEn;
    logic [31:0] miso;
    logic [31:0] expMosi;
    int          expRdCnt;
    logic [7:0]  expRdLast;
    int          expBusy;
    int          expCsLow;
    int          expHs;
    int          expOffers;
    logic        expUf;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] byteAt(input logic [31:0] word, input int idx);
    logic [31:0] w;
    w = word;
    if (idx > 3) return 8'h00;
    return w[31-8*idx -: 8];
  endfunction

  function automatic vec_t mkVec(input string name, input logic [23:0] len,
      input logic [23:0] wrLen, input logic [31:0] tx, input logic vldEn,
      input logic [31:0] miso, input logic [31:0] expMosi, input int expRdCnt,
      input logic [7:0] expRdLast, input int expBusy, input int expCsLow,
      input int expHs, input int expOffers, input logic expUf);
    vec_t v;
    v.name = name; v.len = len; v.wrLen = wrLen; v.tx = tx; v.vldEn = vldEn;
    v.miso = miso; v.expMosi = expMosi; v.expRdCnt = expRdCnt;
    v.expRdLast = expRdLast; v.expBusy = expBusy; v.expCsLow = expCsLow;
    v.expHs = expHs; v.expOffers = expOffers; v.expUf = expUf;
    return v;
  endfunction

  // Runs one transaction, acting as TX byte source and SPI slave, and
  // compares everything observed against the vector's expectations.
  task automatic applyStimulus(input vec_t v);
    int busyCnt = 0, csLow = 0, doneCnt = 0, rdCnt = 0, hs = 0, offers = 0;
    int rises = 0, viol = 0, byteIdx = 0;
    logic [31:0] mosiCap = '0;
    logic [7:0]  rdLast = '0;
    logic        prevSck, prevMosi, prevClkEn;
    bit          finished = 0;
    @(negedge clock);
    req_len    = v.len;
    req_wr_len = v.wrLen;
    request    = 1'b1;
    wr_data    = byteAt(v.tx, 0);
    wr_vld     = v.vldEn;
    spi_miso   = v.miso[31];
    prevSck    = spi_sck;
    prevMosi   = spi_mosi;
    prevClkEn  = clk_en;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clock);
      request = 1'b0;
      if (busy) busyCnt++;
      if (!spi_cs_n) csLow++;
      if (done) doneCnt++;
      if (spi_sck && !prevSck) begin
        if (rises < 32) mosiCap[31-rises] = spi_mosi;
        rises++;
      end
      if (spi_mosi !== prevMosi && !prevClkEn) viol++;
      if (spi_sck && spi_cs_n) viol++;
      if (rd_vld) begin
        if (rdCnt < 4) checkOutput({v.name, " rd_data byte"}, rd_data, byteAt(v.miso, rdCnt));
        rdLast = rd_data;
        rdCnt++;
      end
      wr_data = byteAt(v.tx, byteIdx);
      wr_vld  = v.vldEn;
      if (wr_ready && clk_en) begin
        offers++;
        if (wr_vld) begin
          hs++;
          byteIdx++;
        end
      end
      spi_miso  = (rises < 32) ? v.miso[31-rises] : 1'b0;
      prevSck   = spi_sck;
      prevMosi  = spi_mosi;
      prevClkEn = clk_en;
      if (doneCnt > 0 && !busy) finished = 1;
    end
    wr_vld = 1'b0;
    checkOutput({v.name, " completed"}, 32'(finished), 32'd1);
    checkOutput({v.name, " mosi"}, mosiCap, v.expMosi);
    checkOutput({v.name, " sck rises"}, rises, 32'(v.len));
    checkOutput({v.name, " rd_vld pulses"}, rdCnt, v.expRdCnt);
    checkOutput({v.name, " last rd_data"}, 32'(rdLast), 32'(v.expRdLast));
    checkOutput({v.name, " busy cycles"}, busyCnt, v.expBusy);
    checkOutput({v.name, " cs_n low cycles"}, csLow, v.expCsLow);
    checkOutput({v.name, " wr handshakes"}, hs, v.expHs);
    checkOutput({v.name, " wr boundaries"}, offers, v.expOffers);
    checkOutput({v.name, " wr_underflow"}, 32'(wr_underflow), 32'(v.expUf));
    checkOutput({v.name, " done pulses"}, doneCnt, 1);
    checkOutput({v.name, " protocol violations"}, viol, 0);
  endtask

  initial begin
    int segs, gap, busyTot, doneCnt, rises;
    logic prevBusy, prevSck;
    bit reached;

    vecs[0] = mkVec("id_read", 24'd32, 24'd32, 32'h9F01_0000, 1'b1, 32'hFFEF_4018,
                    32'h9F01_0000, 4, 8'h18, 133, 132, 4, 4, 1'b0);
    vecs[1] = mkVec("partial_wr", 24'd16, 24'd8, 32'hA500_0000, 1'b1, 32'h3C96_0000,
                    32'hA500_0000, 2, 8'h96, 69, 68, 1, 1, 1'b0);
    vecs[2] = mkVec("underflow", 24'd16, 24'd16, 32'hDEAD_BEEF, 1'b0, 32'h1234_0000,
                    32'h0000_0000, 2, 8'h34, 69, 68, 0, 2, 1'b1);
    vecs[3] = mkVec("zero_len", 24'd0, 24'd8, 32'hFF00_0000, 1'b1, 32'hFFFF_FFFF,
                    32'h0000_0000, 0, 8'h00, 1, 0, 0, 0, 1'b0);
    vecs[4] = mkVec("wr_clamp", 24'd8, 24'd20, 32'h5A00_0000, 1'b1, 32'hC300_0000,
                    32'h5A00_0000, 1, 8'hC3, 37, 36, 1, 1, 1'b0);
    vecs[5] = mkVec("partial_rx", 24'd12, 24'd12, 32'hDEAD_0000, 1'b1, 32'h7B50_0000,
                    32'hDEA0_0000, 1, 8'h7B, 53, 52, 2, 2, 1'b0);
    vecs[6] = mkVec("rx_only", 24'd24, 24'd0, 32'h0000_0000, 1'b1, 32'hA1B2_C300,
                    32'h0000_0000, 3, 8'hC3, 101, 100, 0, 0, 1'b0);

    // Reset values, checked while reset is held and after release.
    #3;
    checkOutput("reset outputs held",
                {spi_cs_n, spi_sck, spi_mosi, busy, done, clk_en, wr_ready, rd_vld, wr_underflow},
                9'b1_0000_0000);
    checkOutput("reset rd_data", rd_data, 8'h00);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    checkOutput("outputs after release",
                {spi_cs_n, spi_sck, spi_mosi, busy, done, clk_en, wr_ready, rd_vld, wr_underflow},
                9'b1_0000_0000);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d: %s", i, vecs[i].name);
      applyStimulus(vecs[i]);
    end

    // Request held high: two len-8 transactions separated by one IDLE cycle.
    $display("[TB] back-to-back requests");
    @(negedge clock);
    req_len = 24'd8; req_wr_len = 24'd8; wr_data = 8'h11; wr_vld = 1'b1;
    request = 1'b1;
    segs = 0; gap = 0; busyTot = 0; doneCnt = 0; prevBusy = busy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (busy && !prevBusy) segs++;
      if (busy) busyTot++;
      if (!busy && segs == 1 && doneCnt == 1) gap++;
      if (done) begin
        doneCnt++;
        if (doneCnt == 2) request = 1'b0;
      end
      prevBusy = busy;
      if (doneCnt == 2 && !busy) break;
    end
    repeat (5) begin
      @(negedge clock);
      if (busy && !prevBusy) segs++;
      prevBusy = busy;
    end
    wr_vld = 1'b0;
    checkOutput("b2b busy segments", segs, 2);
    checkOutput("b2b idle gap", gap, 1);
    checkOutput("b2b busy cycles", busyTot, 74);
    checkOutput("b2b done pulses", doneCnt, 2);

    // Asynchronous reset in the middle of bit 10.
    $display("[TB] mid-transaction reset");
    @(negedge clock);
    req_len = 24'd32; req_wr_len = 24'd32; wr_data = 8'h55; wr_vld = 1'b1;
    request = 1'b1;
    rises = 0; reached = 0; prevSck = spi_sck;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clock);
      request = 1'b0;
      if (spi_sck && !prevSck) rises++;
      prevSck = spi_sck;
      if (rises == 10) begin
        reached = 1;
        break;
      end
    end
    checkOutput("reached bit 10", 32'(reached), 32'd1);
    checkOutput("in shift before reset", {spi_cs_n, spi_sck, busy}, 3'b011);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset cs_n/sck/busy/done", {spi_cs_n, spi_sck, busy, done}, 4'b1000);
    doneCnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) doneCnt++;
    end
    rst_n = 1'b1;
    wr_vld = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done) doneCnt++;
    end
    checkOutput("no done after abort", doneCnt, 0);
    checkOutput("idle after abort", {spi_cs_n, busy}, 2'b10);

    $display("[TB] rerun after reset");
    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/spi_bit_engine.md
SPI_BIT_ENGINE -- requirements
Module: spi_bit_engine

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data byte width.
REQ-002 SHALL have parameter CLK_DIV, default 4, clock cycles per SCK period; must be even and >=2.
REQ-003 SHALL have ports `clock` (in, 1, sole clock) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports:
- `request` (in, 1): transaction request level.
- `req_len` (in, 24): total SCK bits.
- `req_wr_len` (in, 24): bits driven from wr_data.
- `busy` (out, 1): transaction in progress.
- `done` (out, 1): one-cycle end pulse.
REQ-005 SHALL have ports:
- `wr_data` (in, DSIZE): next TX byte.
- `wr_vld` (in, 1): wr_data valid.
- `wr_ready` (out, 1): engine wants a byte.
- `clk_en` (out, 1): bit-boundary strobe.
REQ-006 SHALL have ports:
- `rd_data` (out, DSIZE): last complete RX byte.
- `rd_vld` (out, 1): rd_data updated.
- `wr_underflow` (out, 1): sticky missing-byte flag.
REQ-007 SHALL have ports `spi_cs_n` (out, 1), `spi_sck` (out, 1), `spi_mosi` (out, 1) and `spi_miso` (in, 1).

Function
REQ-008 SHALL implement states IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
REQ-009 IDLE with request=1 SHALL latch req_len and min(req_wr_len, req_len), clear wr_underflow, and go to CS_SETUP.
- Exception: if req_len=0, SHALL go directly to DONE with CS untouched.
REQ-010 request SHALL be sampled only in IDLE; a request held high after DONE SHALL start a new transaction.
REQ-011 busy SHALL be 1 in CS_SETUP, SHIFT, CS_HOLD and DONE, and 0 in IDLE.
- busy rises the cycle after request is sampled.
REQ-012 spi_cs_n SHALL be 0 from CS_SETUP entry through CS_HOLD exit; CS_SETUP and CS_HOLD each last CLK_DIV/2 cycles.
REQ-013 SPI mode 0 (CPOL=0, CPHA=0): in SHIFT, spi_sck SHALL be 0 for the first CLK_DIV/2 cycles of each bit period and 1 for the rest.
REQ-014 clk_en SHALL pulse for one cycle at the last clock of every SHIFT bit period, and in the last CS_SETUP cycle; otherwise 0.
REQ-015 spi_mosi SHALL change only at a clk_en cycle and SHALL be sent MSB first.
- Bits at index >= latched wr length SHALL drive 0.
REQ-016 wr_ready SHALL be 1 when the next bit starts a byte (bit index mod DSIZE = 0) and is below the latched wr length.
- A byte is consumed when wr_ready, wr_vld and clk_en are all 1 in the same cycle.
REQ-017 If wr_ready and clk_en are 1 with wr_vld=0, the engine SHALL set wr_underflow, shift 0s for that byte, and continue without stalling.
REQ-018 spi_miso SHALL be sampled at every SCK rising edge, MSB first.
- After each DSIZE samples, rd_data SHALL update and rd_vld SHALL pulse for one cycle.
- A trailing partial byte SHALL NOT raise rd_vld.
REQ-019 After the last bit period ends (bit count = req_len), state SHALL go to CS_HOLD, then DONE for one cycle with done=1, then IDLE.
REQ-020 Bit counters SHALL be 24-bit with no wrap; req_len = 2^24-1 SHALL complete correctly.
REQ-021 Transaction length in cycles SHALL be CLK_DIV/2 + req_len*CLK_DIV + CLK_DIV/2 + 1.

Reset
REQ-022 At reset, outputs SHALL be: spi_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, clk_en=0, wr_ready=0, rd_vld=0, rd_data=0, wr_underflow=0; state=IDLE.
REQ-023 Reset asserted mid-transaction SHALL force the REQ-022 values immediately (asynchronously) and abandon the transaction.
- No done pulse SHALL be generated.

Structure
REQ-024 The state enum and the SPI mode-0 constants SHALL live in the shared package spi_pkg.
REQ-025 The SCK divider (spi_sck, clk_en, sample strobe) SHALL be the sub-module spi_sck_gen; the FSM, shift registers and counters SHALL remain in spi_bit_engine.

Verification
REQ-026 ID read, CLK_DIV=4, req_len=req_wr_len=32:
- Stimulus: TX 9F,01,00,00; MISO FF,EF,40,18.
- Required: MOSI 9F01_0000; rd_vld 4 pulses; rd_data=18 after the last pulse; busy high 2+128+2+1=133 cycles.
REQ-027 req_len=16, req_wr_len=8, TX A5:
- Required: one wr_ready handshake; MOSI A5 then 00; wr_ready never rises for byte 2.
REQ-028 req_len=16, wr_vld held 0 at the first boundary:
- Required: wr_underflow=1; MOSI all 0; done still pulses.
REQ-029 rst_n=0 at SHIFT bit 10:
- Required: same cycle cs_n=1, sck=0, busy=0; no done pulse; a later request runs normally.
REQ-030 req_len=0 with request=1:
- Required: cs_n stays 1; busy high 1 cycle; done pulses once.
REQ-031 request held high across two transactions of req_len=8:
- Required: two back-to-back transactions, with busy low for exactly 1 cycle (IDLE) between them.
